// File: rtl/game_pkg.sv
// Shared types and default constants for the frogger game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        DEATH     = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    localparam int unsigned DEF_START_LIVES  = 3;
    localparam int unsigned DEF_DEATH_FRAMES = 60;
    localparam int unsigned DEF_WIN_FRAMES   = 90;
    localparam int unsigned DEF_MAX_LEVEL    = 7;
    localparam int unsigned DEF_SCORE_W      = 8;

    // Bits needed to hold counts 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Frame counter shared by the DEATH and LEVEL_UP waits; done fires on the
// frame_tick that reaches the selected last count.
module frame_timer
    import game_pkg::*;
#(
    parameter int unsigned MAX_TERM = DEF_WIN_FRAMES
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             clear_i,
    input  logic                             frame_tick_i,
    input  logic [cnt_width(MAX_TERM)-1:0]   last_i,
    output logic                             done_o
);

    localparam int unsigned CW = cnt_width(MAX_TERM);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        done_o  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (frame_tick_i) begin
            if (count_q == last_i) begin
                done_o  = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Round/lives/level sequencer: turns collision, goal and frame events into
// round resets, movement freeze, difficulty level, score and audio strobes.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned START_LIVES  = DEF_START_LIVES,
    parameter int unsigned DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int unsigned WIN_FRAMES   = DEF_WIN_FRAMES,
    parameter int unsigned MAX_LEVEL    = DEF_MAX_LEVEL,
    parameter int unsigned SCORE_W      = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               collision,
    input  logic               reached_end,
    output logic [2:0]         game_state,
    output logic               round_reset,
    output logic               freeze,
    output logic [2:0]         lives,
    output logic [2:0]         level,
    output logic [SCORE_W-1:0] score,
    output logic               win_strobe,
    output logic               lose_strobe
);

    localparam int unsigned FRAME_MAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
    localparam int unsigned FCW       = cnt_width(FRAME_MAX);

    game_state_t        state_q;
    logic               round_reset_q;
    logic               freeze_q;
    logic               win_q;
    logic               lose_q;
    logic [2:0]         lives_q;
    logic [2:0]         level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   score_sum;
    logic [2:0]         start_sync_q;
    logic               start_evt_q;
    logic               timer_clear;
    logic               timer_done;
    logic [FCW-1:0]     timer_last;

    // Two synchronizer stages, one history stage, then a registered edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_sync_q <= '0;
            start_evt_q  <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], start_btn};
            start_evt_q  <= start_sync_q[1] & ~start_sync_q[2];
        end
    end

    always_comb begin
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(level_q) + (SCORE_W+1)'(1);
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        level_d   = (level_q >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : level_q + 3'd1;
    end

    // Counter is held at zero outside the two waiting states, so entry always starts from 0.
    assign timer_clear = (state_q != DEATH) && (state_q != LEVEL_UP);
    assign timer_last  = (state_q == DEATH) ? FCW'(DEATH_FRAMES - 1) : FCW'(WIN_FRAMES - 1);

    frame_timer #(
        .MAX_TERM (FRAME_MAX)
    ) u_frame_timer (
        .clk_i        (clk),
        .reset_i      (reset),
        .clear_i      (timer_clear),
        .frame_tick_i (frame_tick),
        .last_i       (timer_last),
        .done_o       (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            round_reset_q <= 1'b0;
            freeze_q      <= 1'b1;
            lives_q       <= 3'(START_LIVES);
            level_q       <= '0;
            score_q       <= '0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            round_reset_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            unique case (state_q)
                IDLE, GAME_OVER: begin
                    if (start_evt_q) begin
                        state_q       <= PLAY;
                        freeze_q      <= 1'b0;
                        round_reset_q <= 1'b1;
                        lives_q       <= 3'(START_LIVES);
                        level_q       <= '0;
                        score_q       <= '0;
                    end
                end
                PLAY: begin
                    if (collision) begin
                        state_q  <= DEATH;
                        freeze_q <= 1'b1;
                        lose_q   <= 1'b1;
                        if (lives_q != 3'd0) begin
                            lives_q <= lives_q - 3'd1;
                        end
                    end else if (reached_end) begin
                        state_q  <= LEVEL_UP;
                        freeze_q <= 1'b1;
                        win_q    <= 1'b1;
                        score_q  <= score_d;
                        level_q  <= level_d;
                    end
                end
                DEATH: begin
                    if (timer_done) begin
                        if (lives_q == 3'd0) begin
                            state_q <= GAME_OVER;
                        end else begin
                            state_q       <= PLAY;
                            freeze_q      <= 1'b0;
                            round_reset_q <= 1'b1;
                        end
                    end
                end
                LEVEL_UP: begin
                    if (timer_done) begin
                        state_q       <= PLAY;
                        freeze_q      <= 1'b0;
                        round_reset_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    freeze_q <= 1'b1;
                end
            endcase
        end
    end

    assign game_state  = state_q;
    assign round_reset = round_reset_q;
    assign freeze      = freeze_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign score       = score_q;
    assign win_strobe  = win_q;
    assign lose_strobe = lose_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a behavioural game model predicts every
// strobe event; a negedge monitor pops and compares the DUT status.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int LIVES0 = 3;
    localparam int DFR    = 60;
    localparam int WFR    = 90;
    localparam int MAXL   = 7;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start_btn, collision, reached_end;
    logic [2:0] game_state, lives, level;
    logic       round_reset, freeze, win_strobe, lose_strobe;
    logic [7:0] score;
    logic [2:0] gs4, lv4, lvl4;
    logic       rr4, fr4, ws4, ls4;
    logic [3:0] sc4;

    always #5 clk = ~clk;

    game_ctrl #(
        .START_LIVES (3),
        .DEATH_FRAMES(60),
        .WIN_FRAMES  (90),
        .MAX_LEVEL   (7),
        .SCORE_W     (8)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .collision(collision), .reached_end(reached_end), .game_state(game_state),
        .round_reset(round_reset), .freeze(freeze), .lives(lives), .level(level),
        .score(score), .win_strobe(win_strobe), .lose_strobe(lose_strobe)
    );

    game_ctrl #(
        .SCORE_W(4)
    ) dut4 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .collision(collision), .reached_end(reached_end), .game_state(gs4),
        .round_reset(rr4), .freeze(fr4), .lives(lv4), .level(lvl4),
        .score(sc4), .win_strobe(ws4), .lose_strobe(ls4)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  kind;   // {round_reset, win, lose}
        game_state_t st;
        int          lives;
        int          level;
        int          score8;
        int          score4;
    } exp_t;

    exp_t        expq[$];
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;

    game_state_t m_st;
    int          m_lives, m_level, m_raw, m_ticks;
    bit          p1, p2, p3, p4;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input string info);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: %s", nm, info);
    endtask

    function automatic void push(input logic [2:0] kind);
        exp_t e;
        e.cyc    = cyc + 1;
        e.kind   = kind;
        e.st     = m_st;
        e.lives  = m_lives;
        e.level  = m_level;
        e.score8 = (m_raw > 255) ? 255 : m_raw;
        e.score4 = (m_raw > 15) ? 15 : m_raw;
        expq.push_back(e);
    endfunction

    // Drive one cycle of inputs, advance the game model to the next edge, wait for it.
    task automatic step(input bit pin, input bit col, input bit re, input bit tick, input bit rst);
        bit evt;
        start_btn = pin; collision = col; reached_end = re; frame_tick = tick; reset = rst;
        if (rst) begin
            m_st = IDLE; m_lives = LIVES0; m_level = 0; m_raw = 0; m_ticks = 0;
            p1 = 0; p2 = 0; p3 = 0; p4 = 0;
        end else begin
            evt = p3 & ~p4;
            p4 = p3; p3 = p2; p2 = p1; p1 = pin;
            case (m_st)
                IDLE, GAME_OVER: if (evt) begin
                    m_st = PLAY; m_lives = LIVES0; m_level = 0; m_raw = 0;
                    push(3'b100);
                end
                PLAY: if (col) begin
                    m_st = DEATH; m_ticks = 0;
                    if (m_lives > 0) m_lives--;
                    push(3'b001);
                end else if (re) begin
                    m_st = LEVEL_UP; m_ticks = 0;
                    m_raw += m_level + 1;
                    if (m_level < MAXL) m_level++;
                    push(3'b010);
                end
                DEATH: if (tick) begin
                    m_ticks++;
                    if (m_ticks == DFR) begin
                        if (m_lives == 0) m_st = GAME_OVER;
                        else begin m_st = PLAY; push(3'b100); end
                    end
                end
                LEVEL_UP: if (tick) begin
                    m_ticks++;
                    if (m_ticks == WFR) begin m_st = PLAY; push(3'b100); end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (round_reset || win_strobe || lose_strobe || rr4 || ws4 || ls4) begin
            if (expq.size() == 0) begin
                chk(1'b0, "unexpected_strobe", $sformatf("cyc=%0d got rr/win/lose=%b%b%b (dut4 %b%b%b) required none",
                    cyc, round_reset, win_strobe, lose_strobe, rr4, ws4, ls4));
            end else begin
                e = expq.pop_front();
                chk(cyc == e.cyc && {round_reset, win_strobe, lose_strobe} == e.kind && {rr4, ws4, ls4} == e.kind,
                    "event_timing", $sformatf("got cyc=%0d kind=%b dut4=%b required cyc=%0d kind=%b",
                    cyc, {round_reset, win_strobe, lose_strobe}, {rr4, ws4, ls4}, e.cyc, e.kind));
                chk(game_state == e.st && gs4 == e.st && freeze == (e.st != PLAY) && fr4 == (e.st != PLAY) &&
                    int'(lives) == e.lives && int'(lv4) == e.lives && int'(level) == e.level &&
                    int'(lvl4) == e.level && int'(score) == e.score8 && int'(sc4) == e.score4,
                    "event_status", $sformatf("cyc=%0d got st=%0d frz=%b lives=%0d lvl=%0d score=%0d sc4=%0d required st=%0d lives=%0d lvl=%0d score=%0d sc4=%0d",
                    cyc, game_state, freeze, lives, level, score, sc4, e.st, e.lives, e.level, e.score8, e.score4));
            end
        end
    end

    initial begin
        int n;
        bit pin_r;
        reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; collision = 1'b0; reached_end = 1'b0;
        m_st = IDLE; m_lives = LIVES0; m_level = 0; m_raw = 0; m_ticks = 0;
        p1 = 0; p2 = 0; p3 = 0; p4 = 0;
        @(posedge clk); #1;
        repeat (3) step(0, 0, 0, 1, 1);

        chk(game_state == IDLE && freeze == 1'b1, "reset_state",
            $sformatf("got st=%0d frz=%b required st=0 frz=1", game_state, freeze));
        chk(lives == 3'd3 && level == 3'd0 && score == 8'd0, "reset_counters",
            $sformatf("got lives=%0d lvl=%0d score=%0d required 3/0/0", lives, level, score));
        chk(!round_reset && !win_strobe && !lose_strobe, "reset_strobes",
            $sformatf("got rr/win/lose=%b%b%b required 000", round_reset, win_strobe, lose_strobe));
        chk(gs4 == IDLE && lv4 == 3'd3 && sc4 == 4'd0, "reset_dut4",
            $sformatf("got st=%0d lives=%0d score=%0d required 0/3/0", gs4, lv4, sc4));

        repeat (2) step(0, 0, 0, 1'($urandom_range(0, 1)), 0);

        // Start button held 10 cycles: one event, PLAY four edges after the pin edge.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 1'($urandom_range(0, 1)), 0);
            if (i == 2) chk(game_state == IDLE, "start_latency_early",
                $sformatf("got st=%0d required 0 after 3 edges", game_state));
            if (i == 3) chk(game_state == PLAY && freeze == 1'b0 && lives == 3'd3, "start_latency",
                $sformatf("got st=%0d frz=%b lives=%0d required 1/0/3", game_state, freeze, lives));
        end
        repeat (3) step(0, 0, 0, 0, 0);

        // Collision and goal together: collision wins.
        step(0, 1, 1, 0, 0);
        chk(lose_strobe && !win_strobe && lives == 3'd2 && game_state == DEATH, "both_hit",
            $sformatf("got lose=%b win=%b lives=%0d st=%0d required 1/0/2/2", lose_strobe, win_strobe, lives, game_state));
        for (int i = 0; i < DFR - 1; i++) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
        chk(game_state == DEATH, "death_hold", $sformatf("got st=%0d after 59 ticks required 2", game_state));
        step(0, 0, 0, 1, 0);
        chk(game_state == PLAY && round_reset && freeze == 1'b0, "death_expiry",
            $sformatf("got st=%0d rr=%b frz=%b required 1/1/0", game_state, round_reset, freeze));

        // Winning streak: drives level and both score widths into saturation.
        for (int i = 0; i < 7000; i++)
            step(0, 0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0), 0);
        chk(score == 8'd255 && sc4 == 4'd15 && level == 3'd7, "score_saturated",
            $sformatf("got score=%0d sc4=%0d lvl=%0d required 255/15/7", score, sc4, level));

        // Mixed random play, including game overs and restarts.
        pin_r = 0;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 19) == 0) pin_r = ~pin_r;
            step(pin_r, ($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), 0);
        end

        // Die until the game ends.
        n = 0;
        while (m_st != GAME_OVER && n < 3000) begin
            step(0, (m_st == PLAY || m_st == IDLE), 0, 1, 0);
            if (m_st == IDLE && n % 8 == 0) step(1, 0, 0, 1, 0);
            n++;
        end
        repeat (5) step(0, 1, 1, 1, 0);
        chk(game_state == GAME_OVER && freeze == 1'b1 && lives == 3'd0, "game_over",
            $sformatf("got st=%0d frz=%b lives=%0d required 4/1/0", game_state, freeze, lives));

        repeat (3) step(1, 0, 0, 0, 0);
        n = 0;
        while (m_st != PLAY && n < 10) begin step(0, 0, 0, 0, 0); n++; end
        chk(game_state == PLAY && lives == 3'd3 && score == 8'd0 && level == 3'd0, "restart",
            $sformatf("got st=%0d lives=%0d score=%0d lvl=%0d required 1/3/0/0", game_state, lives, score, level));

        // Reset in the middle of DEATH with the frame counter at 30.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk(game_state == IDLE && freeze == 1'b1 && lives == 3'd3 && score == 8'd0 && level == 3'd0 &&
            !round_reset && !win_strobe && !lose_strobe, "mid_death_reset",
            $sformatf("got st=%0d frz=%b lives=%0d score=%0d lvl=%0d strobes=%b%b%b required 0/1/3/0/0/000",
            game_state, freeze, lives, score, level, round_reset, win_strobe, lose_strobe));
        for (int i = 0; i < 10; i++) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
        chk(game_state == IDLE && freeze == 1'b1 && lives == 3'd3, "idle_ticks",
            $sformatf("got st=%0d frz=%b lives=%0d required 0/1/3", game_state, freeze, lives));

        repeat (3) step(0, 0, 0, 0, 0);
        chk(expq.size() == 0, "scoreboard_drained",
            $sformatf("got %0d pending events required 0", expq.size()));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level game sequencer for the frogger datapath. It consumes the frog/car collision flag, the frog's reached_end flag and a per-frame tick, and runs the round/lives/level state machine. It drives the round reset to the frog and car movers, a movement freeze, the difficulty level for the car speed logic, and one-cycle win/lose strobes for the audio block. It sits in top between the collision logic and the frog, cars and topAudio instances.

Parameters:
- START_LIVES, 3: lives loaded at game start. Range 1..7.
- DEATH_FRAMES, 60: frames spent in DEATH before the round resumes or the game ends.
- WIN_FRAMES, 90: frames spent in LEVEL_UP before the next round starts.
- MAX_LEVEL, 7: level saturation value.
- SCORE_W, 8: score width.

Ports:
- clk  in  1  pixel clock, 25.1 MHz.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame, asserted at VSYNC start.
- start_btn  in  1  raw asynchronous start button.
- collision  in  1  level; frog overlaps a car.
- reached_end  in  1  level; frog is in the goal row.
- game_state  out  3  current FSM state (game_pkg encoding).
- round_reset  out  1  one-cycle pulse; frog returns to init position and cars return to initial positions.
- freeze  out  1  high means the frog ignores dpad input and cars hold position.
- lives  out  3  remaining lives.
- level  out  3  difficulty level, 0..MAX_LEVEL.
- score  out  SCORE_W  accumulated score.
- win_strobe  out  1  one-cycle pulse when a round is won.
- lose_strobe  out  1  one-cycle pulse on each death.

Behaviour:
- All outputs are registered. Values after reset:
  - game_state=IDLE, round_reset=0, freeze=1
  - lives=START_LIVES, level=0, score=0
  - win_strobe=0, lose_strobe=0
  - frame counter=0
- start_btn passes through a 2-flop synchronizer and a rising-edge detector to form start_evt. Latency from a pin edge to start_evt is 3 cycles. Holding the button produces a single event.
- States: IDLE, PLAY, DEATH, LEVEL_UP, GAME_OVER. freeze=1 in every state except PLAY.
- IDLE:
  - start_evt moves to PLAY.
  - lives, score and level are reloaded to START_LIVES, 0 and 0.
  - round_reset pulses in the cycle the state becomes PLAY.
- PLAY:
  - collision=1 moves to DEATH. lives decrements (it never goes below 0) and lose_strobe pulses.
  - reached_end=1 with collision=0 moves to LEVEL_UP. win_strobe pulses.
    - score += level+1, saturating at 2^SCORE_W-1.
    - level increments, saturating at MAX_LEVEL.
  - If collision and reached_end are high in the same cycle, collision wins.
  - start_evt is ignored.
- DEATH:
  - The frame counter clears on entry and increments on each frame_tick.
  - On the frame_tick where counter == DEATH_FRAMES-1: go to GAME_OVER if lives==0, otherwise go to PLAY and pulse round_reset.
  - collision and reached_end are ignored.
- LEVEL_UP: same counter behaviour with WIN_FRAMES. On expiry, go to PLAY and pulse round_reset.
- GAME_OVER: start_evt reloads lives, score and level and goes to PLAY with a round_reset pulse. All other inputs are ignored.
- State changes take effect in the cycle after the triggering input is sampled. round_reset, win_strobe and lose_strobe are high for exactly one cycle and align with the first cycle of the new state.
- The frame counter is wide enough for max(DEATH_FRAMES, WIN_FRAMES). frame_tick outside DEATH and LEVEL_UP has no effect.
- collision that stays high after round_reset does not cause a second death, because the frog is repositioned on the same edge. The FSM requires no extra debounce.
- reset mid-round returns every register to its reset value on the next edge. No strobe is emitted.

Decomposition:
- game_pkg:
  - enum game_state_t {IDLE=0, PLAY=1, DEATH=2, LEVEL_UP=3, GAME_OVER=4}
  - default constants for lives, frame counts and MAX_LEVEL
  - SCORE_W
- Sub-module frame_timer: clear and frame_tick inputs, a terminal-count parameter, and a one-cycle done output. It is instantiated once and reused by DEATH and LEVEL_UP.
- The start-button synchronizer and edge detector stay inline.

Test Plan:
1. Reset, then pulse start_btn high for 10 cycles -> exactly one round_reset; game_state=PLAY 4 cycles after the pin edge; freeze=0; lives=3.
2. In PLAY, assert collision and reached_end in the same cycle -> lose_strobe=1, win_strobe=0, lives=2, state=DEATH. After 60 frame_ticks -> PLAY with round_reset.
3. Three deaths -> lives 3→2→1→0; after the third DEATH timer expires, state=GAME_OVER and freeze=1. start_evt -> PLAY, lives=3, score=0.
4. Win 9 rounds in a row -> score follows 1,3,6,...,28 then +8 per round (36,44); level saturates at 7.
5. Set SCORE_W=4 and keep winning -> score saturates at 15 with no wrap.
6. Assert reset in the middle of DEATH with frame counter=30 -> next cycle state=IDLE, lives=3, no strobe; frame_ticks in IDLE change nothing.
